ntt_bram_stream_io: RTL and testbench

- Streaming load/unload front-end for the 64x18 dual-port coefficient BRAM used by the NTT datapath. That BRAM has registered addresses, so read data is valid one cycle after the address.
- Load phase: accepts 64 coefficients over a valid/ready input stream and writes them to the BRAM, optionally in bit-reversed address order, ready for in-place NTT.
- Unload phase: reads all 64 words in natural order and presents them on a valid/ready output stream. The one-cycle read latency and downstream backpressure are absorbed by a 2-entry output buffer.

---
 rtl/ntt_bram_stream_io.sv | 167 ++++++++++++++++
 tb/tb_ntt_bram_stream_io.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_bram_stream_io.sv
// ntt_bram_stream_io
// Streaming load/unload front-end for the NTT coefficient BRAM.
//   Load:   accepts N = 2^AW words on in_valid/in_ready and writes them to the
//           BRAM, optionally at bit-reversed addresses.
//   Unload: reads the N words in natural order and streams them out on
//           out_valid/out_ready. A 2-entry buffer absorbs the one-cycle BRAM
//           read latency and downstream backpressure.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start_load/start_unload  one-cycle frame requests (load wins if both)
//   in_valid/in_data/in_ready         input stream
//   out_valid/out_data/out_ready/out_last  output stream
//   ram_wr_en/ram_wr_addr/ram_wr_din  BRAM write port
//   ram_rd_addr/ram_rd_dout           BRAM read port (data one cycle after address)
//   busy, load_done, unload_done      status
module ntt_bram_stream_io #(
    parameter int DW     = 18,
    parameter int AW     = 6,
    parameter int BITREV = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_load,
    input  logic          start_unload,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic          out_last,
    output logic          ram_wr_en,
    output logic [AW-1:0] ram_wr_addr,
    output logic [DW-1:0] ram_wr_din,
    output logic [AW-1:0] ram_rd_addr,
    input  logic [DW-1:0] ram_rd_dout,
    output logic          busy,
    output logic          load_done,
    output logic          unload_done
);

    localparam logic [AW:0] N_CNT = (AW+1)'(1 << AW);
    localparam logic [AW:0] LAST_CNT = N_CNT - 1'b1;

    typedef enum logic [1:0] {IDLE, LOAD, UNLOAD} state_t;

    state_t        state_reg;
    logic [AW:0]   lcnt_reg;
    logic [AW:0]   icnt_reg;
    logic [AW:0]   pcnt_reg;
    logic [DW-1:0] buf_reg [2];
    logic          wptr_reg;
    logic          rptr_reg;
    logic [1:0]    count_reg;
    logic          inflight_reg;
    logic [AW-1:0] rd_addr_reg;
    logic          load_done_reg;
    logic          unload_done_reg;

    logic [AW-1:0] lcnt_rev;
    logic          wr_hs;
    logic          pop;
    logic          issue;
    logic [2:0]    occ_next;

    // Bit-reversed view of the load counter.
    generate
        for (genvar gi = 0; gi < AW; gi++) begin : g_rev
            if (BITREV != 0) begin : g_on
                assign lcnt_rev[gi] = lcnt_reg[AW-1-gi];
            end else begin : g_off
                assign lcnt_rev[gi] = lcnt_reg[gi];
            end
        end
    endgenerate

    assign in_ready    = (state_reg == LOAD);
    assign wr_hs       = in_ready && in_valid;
    assign ram_wr_en   = wr_hs;
    assign ram_wr_addr = lcnt_rev;
    assign ram_wr_din  = in_data;

    assign out_valid = (count_reg != 2'd0);
    assign out_data  = buf_reg[rptr_reg];
    assign out_last  = out_valid && (pcnt_reg == LAST_CNT);
    assign pop       = out_valid && out_ready;

    // Occupancy after this cycle's pop: buffered words plus the read in flight.
    // A new read may issue only if it will still have a slot when it lands.
    assign occ_next = 3'({1'b0, count_reg}) + 3'(inflight_reg) - 3'(pop);
    assign issue    = (state_reg == UNLOAD) && (icnt_reg < N_CNT) && (occ_next < 3'd2);

    // Address is presented combinationally in the issue cycle and held otherwise.
    assign ram_rd_addr = issue ? icnt_reg[AW-1:0] : rd_addr_reg;

    assign busy        = (state_reg != IDLE);
    assign load_done   = load_done_reg;
    assign unload_done = unload_done_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            lcnt_reg        <= '0;
            icnt_reg        <= '0;
            pcnt_reg        <= '0;
            wptr_reg        <= 1'b0;
            rptr_reg        <= 1'b0;
            count_reg       <= 2'd0;
            inflight_reg    <= 1'b0;
            rd_addr_reg     <= '0;
            load_done_reg   <= 1'b0;
            unload_done_reg <= 1'b0;
        end else begin
            load_done_reg   <= 1'b0;
            unload_done_reg <= 1'b0;
            inflight_reg    <= issue;

            if (issue) begin
                rd_addr_reg <= icnt_reg[AW-1:0];
                icnt_reg    <= icnt_reg + 1'b1;
            end

            if (inflight_reg) begin
                buf_reg[wptr_reg] <= ram_rd_dout;
                wptr_reg          <= ~wptr_reg;
            end
            if (pop) begin
                rptr_reg <= ~rptr_reg;
                pcnt_reg <= pcnt_reg + 1'b1;
            end
            count_reg <= count_reg + 2'(inflight_reg) - 2'(pop);

            case (state_reg)
                IDLE: begin
                    if (start_load) begin
                        state_reg <= LOAD;
                        lcnt_reg  <= '0;
                    end else if (start_unload) begin
                        state_reg <= UNLOAD;
                        icnt_reg  <= '0;
                        pcnt_reg  <= '0;
                        wptr_reg  <= 1'b0;
                        rptr_reg  <= 1'b0;
                        count_reg <= 2'd0;
                    end
                end
                LOAD: begin
                    if (wr_hs) begin
                        lcnt_reg <= lcnt_reg + 1'b1;
                        if (lcnt_reg == LAST_CNT) begin
                            state_reg     <= IDLE;
                            load_done_reg <= 1'b1;
                        end
                    end
                end
                UNLOAD: begin
                    if (pop && (pcnt_reg == LAST_CNT)) begin
                        state_reg       <= IDLE;
                        unload_done_reg <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ntt_bram_stream_io.sv
// Testbench for ntt_bram_stream_io: BRAM model with registered read, load
// frames (continuous and gapped), unload frames under several backpressure
// patterns with a scoreboard queue, mid-frame reset, and start arbitration.
module tb_ntt_bram_stream_io;

    localparam int DW = 18;
    localparam int AW = 6;
    localparam int N  = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_load;
    logic          start_unload;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          out_last;
    logic          ram_wr_en;
    logic [AW-1:0] ram_wr_addr;
    logic [DW-1:0] ram_wr_din;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_dout;
    logic          busy;
    logic          load_done;
    logic          unload_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ntt_bram_stream_io #(.DW(DW), .AW(AW), .BITREV(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_load   (start_load),
        .start_unload (start_unload),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .ram_wr_en    (ram_wr_en),
        .ram_wr_addr  (ram_wr_addr),
        .ram_wr_din   (ram_wr_din),
        .ram_rd_addr  (ram_rd_addr),
        .ram_rd_dout  (ram_rd_dout),
        .busy         (busy),
        .load_done    (load_done),
        .unload_done  (unload_done)
    );

    // Dual-port BRAM model: registered address, data one cycle later.
    logic [DW-1:0] mem [N];
    logic [DW-1:0] rd_dout_q;
    int            wr_count = 0;

    always @(posedge clk) begin
        if (ram_wr_en) begin
            mem[ram_wr_addr] <= ram_wr_din;
            wr_count         <= wr_count + 1;
        end
        rd_dout_q <= mem[ram_rd_addr];
    end
    assign ram_rd_dout = rd_dout_q;

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"},    32'(in_ready),    32'd0);
        check({tag, "_out_valid"},   32'(out_valid),   32'd0);
        check({tag, "_out_last"},    32'(out_last),    32'd0);
        check({tag, "_wr_en"},       32'(ram_wr_en),   32'd0);
        check({tag, "_busy"},        32'(busy),        32'd0);
        check({tag, "_load_done"},   32'(load_done),   32'd0);
        check({tag, "_unload_done"}, 32'(unload_done), 32'd0);
        check({tag, "_rd_addr"},     32'(ram_rd_addr), 32'd0);
        check({tag, "_wr_addr"},     32'(ram_wr_addr), 32'd0);
    endtask

    // Load N words in_data=k; optional gaps, simultaneous start, and a stray
    // start_unload mid-frame that must be ignored.
    task automatic load_frame(input bit gaps, input bit both, input bit poke_unload);
        int k  = 0;
        int cyc = 0;
        int w0;
        w0 = wr_count;
        @(negedge clk);
        start_load   = 1'b1;
        start_unload = both;
        @(negedge clk);
        start_load   = 1'b0;
        start_unload = 1'b0;
        #1;
        check("load_busy", 32'(busy), 32'd1);
        check("load_in_ready", 32'(in_ready), 32'd1);
        while (k < N && cyc < 2000) begin
            in_valid     = gaps ? (cyc % 3 == 0) : 1'b1;
            in_data      = DW'(k);
            start_unload = poke_unload && (cyc == 10);
            #1;
            if (in_valid) begin
                check("load_wr_en", 32'(ram_wr_en), 32'd1);
                check("load_wr_addr", 32'(ram_wr_addr), 32'(bitrev(AW'(k))));
                k++;
            end else begin
                check("load_gap_wr_en", 32'(ram_wr_en), 32'd0);
            end
            @(negedge clk);
            cyc++;
        end
        in_valid     = 1'b0;
        start_unload = 1'b0;
        if (k < N) check("load_timeout", 32'(k), 32'(N));
        #1;
        check("load_done_pulse", 32'(load_done), 32'd1);
        check("load_end_busy", 32'(busy), 32'd0);
        check("load_write_count", 32'(wr_count - w0), 32'(N));
        $display("load frame gaps=%0d both=%0d: %0d words in %0d cycles", gaps, both, k, cyc);
        @(negedge clk);
        #1;
        check("load_done_clear", 32'(load_done), 32'd0);
        check("load_after_busy", 32'(busy), 32'd0);
        check("load_after_out_valid", 32'(out_valid), 32'd0);
    endtask

    // mode 0: out_ready high, 1: toggling, 2: random stalls.
    // abort_at > 0: assert rst after that many beats.
    task automatic unload_frame(input int mode, input int abort_at);
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] exp_d;
        logic [DW-1:0] held_d;
        logic          held_l;
        int beats   = 0;
        int cyc     = 0;
        bit seen    = 0;
        bit stalled = 0;
        bit aborted = 0;
        held_d = '0;
        held_l = 1'b0;
        for (int a = 0; a < N; a++) exp_q.push_back(DW'(bitrev(AW'(a))));
        @(negedge clk);
        start_unload = 1'b1;
        @(negedge clk);
        start_unload = 1'b0;
        while (beats < N && cyc < 1000) begin
            if (abort_at > 0 && beats == abort_at) begin
                out_ready = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                #1;
                check_idle_outputs("abort");
                $display("unload aborted by reset after %0d beats", beats);
                aborted = 1;
                break;
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 2 == 0);
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            #1;
            if (out_valid && !seen) begin
                seen = 1;
                check("first_valid_cycle", 32'(cyc), 32'd2);
            end
            if (stalled) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", 32'(out_data), 32'(held_d));
                check("stall_last", 32'(out_last), 32'(held_l));
            end
            if (out_valid && out_ready) begin
                exp_d = exp_q.pop_front();
                check("unload_data", 32'(out_data), 32'(exp_d));
                check("unload_last", 32'(out_last), 32'(beats == N - 1));
                check("unload_no_write", 32'(ram_wr_en), 32'd0);
                $display("unload mode=%0d beat %0d data %0h last %0d", mode, beats, out_data, out_last);
                beats++;
                stalled = 0;
            end else if (out_valid) begin
                stalled = 1;
                held_d  = out_data;
                held_l  = out_last;
            end else begin
                stalled = 0;
            end
            @(negedge clk);
            cyc++;
        end
        if (!aborted) begin
            if (beats < N) check("unload_timeout", 32'(beats), 32'(N));
            if (mode == 0) check("full_rate_cycles", 32'(cyc), 32'(N + 2));
            out_ready = 1'b0;
            #1;
            check("unload_done_pulse", 32'(unload_done), 32'd1);
            check("unload_end_busy", 32'(busy), 32'd0);
            check("unload_end_valid", 32'(out_valid), 32'd0);
            @(negedge clk);
            #1;
            check("unload_done_clear", 32'(unload_done), 32'd0);
        end
    endtask

    initial begin
        rst          = 1'b1;
        start_load   = 1'b0;
        start_unload = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        out_ready    = 1'b0;

        // Reset held two cycles with random inputs.
        repeat (2) begin
            @(negedge clk);
            start_load   = 1'($urandom);
            start_unload = 1'($urandom);
            in_valid     = 1'($urandom);
            in_data      = DW'($urandom);
            out_ready    = 1'($urandom);
        end
        @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst          = 1'b0;
        start_load   = 1'b0;
        start_unload = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;

        load_frame(1'b0, 1'b0, 1'b0);
        unload_frame(0, 0);
        unload_frame(1, 0);
        unload_frame(2, 0);
        unload_frame(0, 20);
        unload_frame(0, 0);
        load_frame(1'b1, 1'b0, 1'b1);
        load_frame(1'b0, 1'b1, 1'b0);
        unload_frame(2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
